sprite_pixel_fetch: RTL and testbench
=====================================

// Module: sprite_pixel_fetch
// PURPOSE
//  Reader side of the character sprite ROM selector: per video pixel, decides whether the pixel lies inside the player sprite box,
//  drives char select and 12-bit ROM address (64x64 sprite, row-major), captures 6-bit RRGGBB pixel data, applies transparency.
//  Sits between the VGA timing generator and the pixel mux; outputs are pipeline-aligned with a delayed copy of pix_valid.
// PARAMETERS
//  SPR_W        64      sprite width in pixels (address = row*SPR_W + col, fixed 64 for 12-bit address)
//  SPR_H        64      sprite height in pixels
//  TRANS_KEY    6'h00   ROM colour treated as transparent
//  NUM_CHARS    9       legal char indices 0..NUM_CHARS-1
// PORTS
//  clk          in   1   pixel clock
//  rst          in   1   synchronous active-high reset
//  frame_start  in   1   1-cycle pulse before first active pixel of a frame
//  pix_valid    in   1   current pix_x/pix_y is in visible area
//  pix_x        in   10  current pixel column
//  pix_y        in   10  current pixel row
//  pos_x        in   10  sprite top-left column (sampled at frame_start)
//  pos_y        in   10  sprite top-left row (sampled at frame_start)
//  char_req     in   4   requested character (sampled at frame_start)
//  face_left    in   1   1 = mirror sprite horizontally (sampled at frame_start)
//  char         out  4   char select to sprite ROM selector
//  address      out  12  ROM address
//  rom_data     in   6   ROM pixel, valid combinationally from char/address
//  pix_out      out  6   sprite colour, 0 when no hit
//  hit          out  1   opaque sprite pixel at aligned position
//  out_valid    out  1   pix_valid delayed to align with pix_out/hit
// BEHAVIOUR
//  Reset: char=0, address=0, pix_out=0, hit=0, out_valid=0, latched pos/face cleared, FSM -> IDLE.
//  FSM: IDLE -(frame_start)-> ACTIVE; ACTIVE -(frame_start)-> ACTIVE (relatch); no other transitions except rst.
//   In IDLE, hit=0 and pix_out=0 regardless of inputs; out_valid still tracks pix_valid.
//  Frame latch: on frame_start, latch pos_x, pos_y, face_left, char_req; char_req>=NUM_CHARS latches as 0.
//   Latched values are stable for the whole frame; mid-frame input changes ignored.
//  Stage 1 (cycle n+1): in_box = pix_valid & pix_x>=px & pix_x<px+SPR_W & pix_y>=py & pix_y<py+SPR_H,
//   compare at 11 bits (no wrap when px+SPR_W > 1023). col = pix_x-px, or SPR_W-1-(pix_x-px) when face_left.
//   row = pix_y-py. address register <= {row[5:0],col[5:0]} when in_box, else holds previous value. in_box1 registered.
//  Stage 2 (cycle n+2): hit <= in_box1 & (rom_data != TRANS_KEY); pix_out <= hit ? rom_data : 0.
//  Latency: pix_x/pix_y at cycle n -> pix_out/hit/out_valid at cycle n+2, fixed, no stalls.
//  frame_start coinciding with pix_valid: the pixel uses the newly latched values.
//  rst mid-frame: pipeline flushed, outputs 0 next cycle, remains IDLE until next frame_start.
//  Sprite partially off-screen: only visible part drawn; out-of-box pixels never assert hit.
// CONFIGURATION
//  SPRITE_SCALE2X_EN defined: sprite drawn at 2x (box 2*SPR_W x 2*SPR_H), col/row = offset>>1 (mirror applied after shift);
//   address range and latency unchanged.
//  Not defined: 1:1 mapping as above.
// TESTING
//  pos=(100,50), char_req=3, frame_start, pix=(100,50) -> 2 cycles later char=3, address=0x000, hit if rom_data!=0.
//  pix=(163,113) -> address=0xFFF; pix=(164,113) and (99,50) -> hit=0, pix_out=0.
//  face_left=1, pix=(100,50) -> address=0x03F; pix=(163,50) -> address=0x000.
//  char_req=12 at frame_start -> char=0; change pos_x mid-frame -> box unchanged until next frame_start.
//  rom_data=TRANS_KEY inside box -> hit=0, pix_out=0; rst pulse mid-frame -> outputs 0, no hit until frame_start.
//  SPRITE_SCALE2X_EN: pos=(0,0), pix=(127,127) -> address=0xFFF, hit per rom_data; pix=(128,0) -> hit=0.

Source files
------------

// File: rtl/sprite_pixel_fetch.sv
// -----------------------------------------------------------------------------
// sprite_pixel_fetch
//
// Reader side of the character sprite ROM selector. For every video pixel it
// decides whether the pixel falls inside the player sprite box. It drives the
// char select and the 12-bit row-major ROM address. It captures the 6-bit
// RRGGBB pixel returned by the ROM and applies colour-key transparency.
// Outputs are aligned two cycles after the pixel coordinates. out_valid is
// pix_valid delayed by the same two cycles.
//
// Ports
//   clk          in   1   pixel clock
//   rst          in   1   synchronous active-high reset
//   frame_start  in   1   one-cycle pulse before the first active pixel
//   pix_valid    in   1   pix_x/pix_y lie in the visible area
//   pix_x/pix_y  in   10  current pixel column/row
//   pos_x/pos_y  in   10  sprite top-left corner (latched at frame_start)
//   char_req     in   4   requested character (latched at frame_start)
//   face_left    in   1   mirror horizontally (latched at frame_start)
//   char         out  4   char select to the sprite ROM selector
//   address      out  12  ROM address {row[5:0], col[5:0]}
//   rom_data     in   6   ROM pixel, combinational from char/address
//   pix_out      out  6   sprite colour, 0 when there is no hit
//   hit          out  1   opaque sprite pixel at the aligned position
//   out_valid    out  1   pix_valid aligned with pix_out/hit
//
// Configuration
//   SPRITE_SCALE2X_EN : when defined, the sprite is drawn at double size.
//                       The box is 2*SPR_W x 2*SPR_H and the screen offset is
//                       halved before any mirroring. The address range and
//                       the latency do not change.
// -----------------------------------------------------------------------------
module sprite_pixel_fetch #(
    parameter int          SPR_W     = 64,
    parameter int          SPR_H     = 64,
    parameter logic [5:0]  TRANS_KEY = 6'h00,
    parameter int          NUM_CHARS = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic [3:0]  char_req,
    input  logic        face_left,
    output logic [3:0]  char,
    output logic [11:0] address,
    input  logic [5:0]  rom_data,
    output logic [5:0]  pix_out,
    output logic        hit,
    output logic        out_valid
);

`ifdef SPRITE_SCALE2X_EN
    localparam int SCALE_SH = 1;
`else
    localparam int SCALE_SH = 0;
`endif

    localparam int          PIPE_LEN    = 2;
    localparam logic [10:0] BOX_W       = 11'(SPR_W << SCALE_SH);
    localparam logic [10:0] BOX_H       = 11'(SPR_H << SCALE_SH);
    localparam logic [5:0]  COL_MAX     = 6'(SPR_W - 1);
    localparam logic [4:0]  NUM_CHARS_W = 5'(NUM_CHARS);

    typedef enum logic [0:0] {IDLE, ACTIVE} state_t;

    state_t      state_reg, state_next;
    logic [9:0]  px_reg, py_reg;
    logic        face_reg;
    logic [3:0]  char_reg;
    logic [11:0] address_reg;
    logic        in_box1_reg;
    logic        hit_reg;
    logic [5:0]  pix_out_reg;
    logic        valid_pipe_reg [PIPE_LEN];

    // FSM: frame_start is the only event that moves the state. It enters
    // ACTIVE from IDLE, or stays in ACTIVE and relatches the frame values.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (frame_start) state_next = ACTIVE;
    end

    // Frame latch. The stage-1 logic below sees the incoming values during
    // the frame_start cycle, so a pixel on that cycle already uses the new frame.
    logic [3:0] char_sel;
    assign char_sel = ({1'b0, char_req} < NUM_CHARS_W) ? char_req : 4'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            px_reg   <= '0;
            py_reg   <= '0;
            face_reg <= 1'b0;
            char_reg <= '0;
        end else if (frame_start) begin
            px_reg   <= pos_x;
            py_reg   <= pos_y;
            face_reg <= face_left;
            char_reg <= char_sel;
        end
    end

    logic [9:0]  px_eff, py_eff;
    logic        face_eff, active_eff;
    assign px_eff     = frame_start ? pos_x : px_reg;
    assign py_eff     = frame_start ? pos_y : py_reg;
    assign face_eff   = frame_start ? face_left : face_reg;
    assign active_eff = frame_start | (state_reg == ACTIVE);

    // Box test at 11 bits, so a sprite hanging past column/row 1023 does not
    // wrap around to the left/top edge.
    logic [10:0] x11, y11, px11, py11, off_x, off_y;
    logic        in_box;
    logic [5:0]  col_raw, col, row;

    assign x11  = {1'b0, pix_x};
    assign y11  = {1'b0, pix_y};
    assign px11 = {1'b0, px_eff};
    assign py11 = {1'b0, py_eff};

    assign in_box = active_eff & pix_valid
                  & (x11 >= px11) & (x11 < px11 + BOX_W)
                  & (y11 >= py11) & (y11 < py11 + BOX_H);

    assign off_x   = x11 - px11;
    assign off_y   = y11 - py11;
    // Scale down first, then mirror, so a doubled sprite is mirrored at texel level.
    assign col_raw = 6'(off_x >> SCALE_SH);
    assign row     = 6'(off_y >> SCALE_SH);
    assign col     = face_eff ? (COL_MAX - col_raw) : col_raw;

    // Stage 1. The address only moves inside the box, so the ROM is not
    // toggled outside the sprite.
    always_ff @(posedge clk) begin
        if (rst) begin
            address_reg <= '0;
            in_box1_reg <= 1'b0;
        end else begin
            in_box1_reg <= in_box;
            if (in_box) address_reg <= {row, col};
        end
    end

    // Stage 2: capture the ROM pixel and apply the colour key.
    logic opaque;
    assign opaque = in_box1_reg & (rom_data != TRANS_KEY);

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_reg     <= 1'b0;
            pix_out_reg <= '0;
        end else begin
            hit_reg     <= opaque;
            pix_out_reg <= opaque ? rom_data : 6'd0;
        end
    end

    // pix_valid delay line that matches the two-stage pipeline.
    genvar gi;
    generate
        for (gi = 0; gi < PIPE_LEN; gi++) begin : g_valid
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) valid_pipe_reg[gi] <= 1'b0;
                    else     valid_pipe_reg[gi] <= pix_valid;
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) valid_pipe_reg[gi] <= 1'b0;
                    else     valid_pipe_reg[gi] <= valid_pipe_reg[gi-1];
                end
            end
        end
    endgenerate

    assign char      = char_reg;
    assign address   = address_reg;
    assign hit       = hit_reg;
    assign pix_out   = pix_out_reg;
    assign out_valid = valid_pipe_reg[PIPE_LEN-1];

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// -----------------------------------------------------------------------------
// tb_sprite_pixel_fetch
//
// Self-checking bench for sprite_pixel_fetch. A behavioural ROM answers
// char/address combinationally. A reference model works out the expected box
// membership, address, hit and colour for each pixel with plain integer
// arithmetic. It then delays those expectations by the two-cycle latency.
// The bench runs directed corner cases first and then randomized traffic.
// -----------------------------------------------------------------------------
module tb_sprite_pixel_fetch;

`ifdef SPRITE_SCALE2X_EN
    localparam int SCALE = 2;
`else
    localparam int SCALE = 1;
`endif
    localparam int NUM_CHARS = 9;

    logic        clk = 1'b0;
    logic        rst, frame_start, pix_valid, face_left;
    logic [9:0]  pix_x, pix_y, pos_x, pos_y;
    logic [3:0]  char_req, char;
    logic [11:0] address;
    logic [5:0]  rom_data, pix_out;
    logic        hit, out_valid;

    logic [5:0]  rom [16][4096];

    int checks   = 0;
    int failures = 0;

    sprite_pixel_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .char_req    (char_req),
        .face_left   (face_left),
        .char        (char),
        .address     (address),
        .rom_data    (rom_data),
        .pix_out     (pix_out),
        .hit         (hit),
        .out_valid   (out_valid)
    );

    always #5 clk = ~clk;

    assign rom_data = rom[char][address];

    // Model state
    bit         m_active;
    int         m_px, m_py, m_char;
    bit         m_face;
    int         m_addr;
    bit         s1_v, s1_h, s2_v, s2_h;
    int         s1_p, s2_p;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One pixel-clock cycle: apply inputs, advance the model, check after the edge.
    task automatic cyc(input bit r, input bit fs, input bit pv, input int x, input int y,
                       input int px, input int py, input bit fl, input int cr);
        int  xm, ym, dx, dy, col, row, pixv;
        bit  inb, c_h;
        xm = x & 1023;
        ym = y & 1023;
        rst = r; frame_start = fs; pix_valid = pv;
        pix_x = xm[9:0]; pix_y = ym[9:0];
        pos_x = px[9:0]; pos_y = py[9:0];
        face_left = fl; char_req = cr[3:0];
        if (r) begin
            m_active = 0; m_px = 0; m_py = 0; m_face = 0; m_char = 0; m_addr = 0;
            s1_v = 0; s1_h = 0; s1_p = 0; s2_v = 0; s2_h = 0; s2_p = 0;
        end else begin
            if (fs) begin
                m_active = 1;
                m_px = px & 1023; m_py = py & 1023; m_face = fl;
                m_char = ((cr & 15) < NUM_CHARS) ? (cr & 15) : 0;
            end
            dx  = xm - m_px;
            dy  = ym - m_py;
            inb = m_active && pv && dx >= 0 && dx < 64*SCALE && dy >= 0 && dy < 64*SCALE;
            if (inb) begin
                col = dx / SCALE;
                row = dy / SCALE;
                if (m_face) col = 63 - col;
                m_addr = row * 64 + col;
            end
            pixv = int'(rom[m_char][m_addr]);
            c_h  = inb && (pixv != 0);
            s2_v = s1_v; s2_h = s1_h; s2_p = s1_p;
            s1_v = pv;   s1_h = c_h;  s1_p = c_h ? pixv : 0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", int'(out_valid), int'(s2_v));
        chk("hit",       int'(hit),       int'(s2_h));
        chk("pix_out",   int'(pix_out),   s2_p);
        chk("char",      int'(char),      m_char);
        chk("address",   int'(address),   m_addr);
        $display("cyc rst=%0b fs=%0b pv=%0b pix=(%0d,%0d) -> char=%0d addr=0x%03h hit=%0b pix_out=0x%02h ov=%0b",
                 r, fs, pv, xm, ym, char, address, hit, pix_out, out_valid);
    endtask

    task automatic px_at(input int x, input int y);
        cyc(0, 0, 1, x, y, 0, 0, 0, 0);
    endtask

    initial begin
        for (int c = 0; c < 16; c++)
            for (int a = 0; a < 4096; a++)
                rom[c][a] = ($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom_range(1, 63));
        // Known colours for the directed corner points
        rom[3][0]     = 6'h2A;
        rom[3][12'h3F] = 6'h15;
        rom[3][12'hFFF] = 6'h00;

        // Reset and idle traffic: nothing may hit before the first frame_start
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_hit", int'(hit), 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 100 + i, 50, 100, 50, 0, 3);

        // Directed: box at (100,50), char 3
        cyc(0, 1, 1, 100, 50, 100, 50, 0, 3);
        px_at(163, 113);
        px_at(164, 113);
        px_at(99, 50);
        px_at(120, 60);
        cyc(0, 0, 1, 110, 55, 300, 300, 0, 3); // pos change mid-frame ignored
        px_at(0, 0); px_at(0, 0);
        // Mirrored frame
        cyc(0, 1, 1, 100, 50, 100, 50, 1, 3);
        px_at(163, 50);
        px_at(0, 0); px_at(0, 0);
        // Illegal char request latches as 0
        cyc(0, 1, 0, 0, 0, 200, 200, 0, 12);
        px_at(210, 210); px_at(0, 0); px_at(0, 0);
        // Sprite hanging off the bottom-right corner must not wrap
        cyc(0, 1, 0, 0, 0, 1000, 1000, 0, 5);
        px_at(1010, 1010); px_at(5, 5); px_at(5, 1010); px_at(0, 0); px_at(0, 0);
        // Reset mid-frame: pipeline flushed, no hits until the next frame_start
        cyc(0, 1, 1, 120, 60, 100, 50, 0, 3);
        cyc(1, 0, 1, 121, 60, 100, 50, 0, 3);
        for (int i = 0; i < 5; i++) px_at(110 + i, 60);

        // Randomized traffic clustered around the latched box
        begin
            int bx = 100, by = 50;
            for (int i = 0; i < 3000; i++) begin
                bit r, fs, fl;
                int px, py, cr;
                r  = ($urandom_range(0, 499) == 0);
                fs = ($urandom_range(0, 149) == 0);
                fl = 1'($urandom_range(0, 1));
                cr = $urandom_range(0, 15);
                px = ($urandom_range(0, 7) == 0) ? $urandom_range(900, 1023) : $urandom_range(0, 1023);
                py = ($urandom_range(0, 7) == 0) ? $urandom_range(900, 1023) : $urandom_range(0, 1023);
                if (fs) begin bx = px; by = py; end
                cyc(r, fs, ($urandom_range(0, 4) != 0),
                    bx + $urandom_range(0, 64*SCALE + 20) - 10,
                    by + $urandom_range(0, 64*SCALE + 20) - 10,
                    px, py, fl, cr);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
